// File: rtl/edge_period_meter.sv
// Measures high time and period of a signal from its rising/falling edge pulses
// and publishes each result over valid/ready. Optional abandon-on-silence: EDGE_TIMEOUT_EN.
module edge_period_meter #(
  parameter real THRESH  = 0.5,
  parameter int  CNT_W   = 16,
  parameter int  TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  real              rising_edge,
  input  real              falling_edge,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_sat,
  output logic             overrun,
  output logic [7:0]       edge_cnt,
  output logic             timeout,
  output logic [1:0]       fsm_state
);

  // Handshake: a result transfers on any posedge where meas_valid & meas_ready;
  // while meas_valid & ~meas_ready, period/high_time/meas_sat hold steady.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s, f_s, r_s_prev, f_s_prev;
  logic             rise_ev, fall_ev, rise_ok, fall_ok;
  logic [1:0]       state;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic             sat;
  logic             per_max, hi_max, start, publish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s      <= 1'b0;
      f_s      <= 1'b0;
      r_s_prev <= 1'b0;
      f_s_prev <= 1'b0;
    end else begin
      r_s      <= (rising_edge > THRESH);
      f_s      <= (falling_edge > THRESH);
      r_s_prev <= r_s;
      f_s_prev <= f_s;
    end
  end

  assign rise_ev = r_s & ~r_s_prev;
  assign fall_ev = f_s & ~f_s_prev;
  // Coincident edges are treated as a glitch and cancel each other.
  assign rise_ok = rise_ev & ~fall_ev;
  assign fall_ok = fall_ev & ~rise_ev;

  assign per_max = (per_cnt == CNT_MAX);
  assign hi_max  = (hi_cnt == CNT_MAX);
  assign start   = rise_ok & ((state == IDLE) | (state == LOW));
  assign publish = rise_ok & (state == LOW);

`ifdef EDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            accepted, to_hit;

  assign accepted = (state == HIGH) ? fall_ok : rise_ok;
  assign to_hit   = (state != IDLE) && !accepted && (idle_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_hit;
      if ((state == IDLE) || accepted || to_hit) idle_cnt <= '0;
      else                                      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // Feature compiled out; the expression is constant zero.
  assign timeout = 1'b0 && (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      sat      <= 1'b0;
      edge_cnt <= 8'd0;
    end else begin
      if (start) begin
        state    <= HIGH;
        per_cnt  <= CNT_W'(1);
        hi_cnt   <= CNT_W'(1);
        sat      <= 1'b0;
        edge_cnt <= edge_cnt + 8'd1;
      end else begin
        case (state)
          HIGH: begin
            if (!per_max) per_cnt <= per_cnt + 1'b1;
            if (fall_ok) state <= LOW;
            else if (!hi_max) hi_cnt <= hi_cnt + 1'b1;
            if (per_max || (hi_max && !fall_ok)) sat <= 1'b1;
          end
          LOW: begin
            if (!per_max) per_cnt <= per_cnt + 1'b1;
            else          sat     <= 1'b1;
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
`ifdef EDGE_TIMEOUT_EN
      if (to_hit) state <= IDLE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_sat   <= 1'b0;
      overrun    <= 1'b0;
    end else if (publish) begin
      if (!meas_valid || meas_ready) begin
        meas_valid <= 1'b1;
        period     <= per_cnt;
        high_time  <= hi_cnt;
        meas_sat   <= sat;
      end else begin
        overrun <= 1'b1;
      end
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

  assign fsm_state = state;

endmodule
